// File: rtl/spell_wb_sram_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spell_wb_sram_responder_pkg
// Brief   : Shared bus widths, FSM encoding and WAIT_STATES range check.
// Revision: 1.0
// ============================================================================
package spell_wb_sram_responder_pkg;

  localparam int c_BUS_DATA_W     = 32;
  localparam int c_BUS_ADR_W      = 32;
  localparam int c_BUS_SEL_W      = 4;
  localparam int c_WAIT_CNT_W     = 4;
  localparam int c_WAIT_STATES_MAX = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  function automatic bit wait_states_legal(input int ws);
    return (ws >= 0) && (ws <= c_WAIT_STATES_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spell_wb_sram_array.sv
`default_nettype none
// ============================================================================
// Module  : spell_wb_sram_array
// Brief   : Single-port 32-bit word array, byte-write enables, registered read.
// Revision: 1.0
// ============================================================================
module spell_wb_sram_array
  import spell_wb_sram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    wr_en_i,
  input  logic [c_BUS_SEL_W-1:0]  be_i,
  input  logic                    rd_en_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [c_BUS_DATA_W-1:0] wdata_i,
  output logic [c_BUS_DATA_W-1:0] rdata_o
);

  localparam int c_DEPTH = 2 ** ADDR_WIDTH;

  logic [c_BUS_DATA_W-1:0] mem_q [c_DEPTH];
  logic [c_BUS_DATA_W-1:0] rdata_q;

  // Storage is deliberately left without reset so it maps onto block RAM.
  always_ff @(posedge clock_i) begin
    if (wr_en_i) begin
      for (int b = 0; b < c_BUS_SEL_W; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      rdata_q <= '0;
    end else if (rd_en_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/spell_wb_sram_responder.sv
`default_nettype none
// ============================================================================
// Module  : spell_wb_sram_responder
// Brief   : Wishbone classic SRAM responder with programmable wait states.
// Revision: 1.0
// ============================================================================
module spell_wb_sram_responder
  import spell_wb_sram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 9,
  parameter int WAIT_STATES = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  input  logic [c_BUS_SEL_W-1:0]  wb_sel_i,
  input  logic [c_BUS_ADR_W-1:0]  wb_adr_i,
  input  logic [c_BUS_DATA_W-1:0] wb_dat_i,
  output logic                    wb_ack_o,
  output logic [c_BUS_DATA_W-1:0] wb_dat_o,
  output logic                    busy
);

  if (!wait_states_legal(WAIT_STATES)) begin : g_ws_range_err
    $error("spell_wb_sram_responder: WAIT_STATES must be within 0..15");
  end

  localparam logic [c_WAIT_CNT_W-1:0] c_WAIT_INIT =
    (WAIT_STATES > 0) ? c_WAIT_CNT_W'(WAIT_STATES - 1) : '0;

  state_e                  state_q, state_d;
  logic [c_WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                    ack_q;
  logic                    we_q;
  logic                    oor_q;
  logic [c_BUS_SEL_W-1:0]  sel_q;
  logic [ADDR_WIDTH-1:0]   adr_q;
  logic [c_BUS_DATA_W-1:0] dat_q;

  logic                    w_req;
  logic                    w_accept;
  logic                    w_req_oor;
  logic                    w_enter_ack;
  logic                    w_cur_we;
  logic                    w_cur_oor;
  logic [c_BUS_SEL_W-1:0]  w_cur_sel;
  logic [ADDR_WIDTH-1:0]   w_cur_adr;
  logic [c_BUS_DATA_W-1:0] w_cur_dat;
  logic [c_BUS_DATA_W-1:0] w_rdata;

  assign w_req     = wb_cyc_i & wb_stb_i;
  assign w_accept  = (state_q == ST_IDLE) & w_req;
  assign w_req_oor = (wb_adr_i >> ADDR_WIDTH) != '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (w_req) begin
          if (WAIT_STATES == 0) begin
            state_d = ST_ACK;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = c_WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (!w_req) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= w_enter_ack;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      we_q  <= 1'b0;
      oor_q <= 1'b0;
      sel_q <= '0;
      adr_q <= '0;
      dat_q <= '0;
    end else if (w_accept) begin
      we_q  <= wb_we_i;
      oor_q <= w_req_oor;
      sel_q <= wb_sel_i;
      adr_q <= wb_adr_i[ADDR_WIDTH-1:0];
      dat_q <= wb_dat_i;
    end
  end

  // With zero wait states the array is addressed straight from the bus,
  // because the request latches only fill on that same edge.
  assign w_cur_we    = (state_q == ST_IDLE) ? wb_we_i   : we_q;
  assign w_cur_oor   = (state_q == ST_IDLE) ? w_req_oor : oor_q;
  assign w_cur_sel   = (state_q == ST_IDLE) ? wb_sel_i  : sel_q;
  assign w_cur_adr   = (state_q == ST_IDLE) ? wb_adr_i[ADDR_WIDTH-1:0] : adr_q;
  assign w_cur_dat   = (state_q == ST_IDLE) ? wb_dat_i  : dat_q;
  assign w_enter_ack = (state_d == ST_ACK) & (state_q != ST_ACK);

  spell_wb_sram_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clock_i (clock),
    .reset_i (reset),
    .wr_en_i (w_enter_ack & w_cur_we & ~w_cur_oor & ~reset),
    .be_i    (w_cur_sel),
    .rd_en_i (w_enter_ack & ~w_cur_we & ~w_cur_oor),
    .addr_i  (w_cur_adr),
    .wdata_i (w_cur_dat),
    .rdata_o (w_rdata)
  );

  assign wb_ack_o = ack_q;
  assign wb_dat_o = ((state_q == ST_ACK) && !we_q && !oor_q) ? w_rdata : '0;
  assign busy     = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spell_wb_sram_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_spell_wb_sram_responder
// Brief   : Self-checking bench; two responders (1 and 3 wait states).
// Revision: 1.0
// ============================================================================
module tb_spell_wb_sram_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cyc [2];
  logic        stb [2];
  logic        we  [2];
  logic [3:0]  sel [2];
  logic [31:0] adr [2];
  logic [31:0] dat [2];
  logic        ack [2];
  logic [31:0] rdat[2];
  logic        busy[2];

  int errors = 0;
  int checks = 0;

  logic [31:0] mem_m [2][512];

  always #5 clock = ~clock;

  spell_wb_sram_responder #(.ADDR_WIDTH(9), .WAIT_STATES(1)) u_dut_ws1 (
    .clock(clock), .reset(reset),
    .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we[0]), .wb_sel_i(sel[0]),
    .wb_adr_i(adr[0]), .wb_dat_i(dat[0]),
    .wb_ack_o(ack[0]), .wb_dat_o(rdat[0]), .busy(busy[0])
  );

  spell_wb_sram_responder #(.ADDR_WIDTH(9), .WAIT_STATES(3)) u_dut_ws3 (
    .clock(clock), .reset(reset),
    .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we[1]), .wb_sel_i(sel[1]),
    .wb_adr_i(adr[1]), .wb_dat_i(dat[1]),
    .wb_ack_o(ack[1]), .wb_dat_o(rdat[1]), .busy(busy[1])
  );

  function automatic int ws_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Reference memory: in-range writes merge selected bytes, others vanish.
  function automatic void m_write(input int d, input logic [31:0] a,
                                  input logic [3:0] s, input logic [31:0] wd);
    if (a < 32'd512) begin
      for (int l = 0; l < 4; l++) begin
        if (s[l]) mem_m[d][a][8*l +: 8] = wd[8*l +: 8];
      end
    end
  endfunction

  function automatic logic [31:0] m_read(input int d, input logic [31:0] a);
    return (a < 32'd512) ? mem_m[d][a] : 32'h0;
  endfunction

  task automatic xact(input int d, input logic w, input logic [3:0] s,
                      input logic [31:0] a, input logic [31:0] wd,
                      output int lat, output logic [31:0] rd, output logic busy1,
                      output logic post_ack, output logic [31:0] post_dat,
                      output logic post_busy);
    int n;
    n = 0; lat = -1; rd = '0; busy1 = 1'b0;
    @(negedge clock);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; sel[d] = s; adr[d] = a; dat[d] = wd;
    while (lat < 0 && n < 40) begin
      @(posedge clock); #1; n++;
      if (n == 1) busy1 = busy[d];
      if (ack[d] === 1'b1) begin
        lat = n;
        rd  = rdat[d];
      end
    end
    @(negedge clock);
    cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
    @(posedge clock); #1;
    post_ack = ack[d]; post_dat = rdat[d]; post_busy = busy[d];
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ack[d] !== 1'b0) begin errors++; $display("FAIL reset_ack[%0d]: got %b want 0", d, ack[d]); end
      checks++;
      if (rdat[d] !== 32'h0) begin errors++; $display("FAIL reset_dat[%0d]: got %h want 0", d, rdat[d]); end
      checks++;
      if (busy[d] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b want 0", d, busy[d]); end
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rd, pd; logic b1, pa, pb;
    xact(0, 1'b1, 4'hF, 32'h005, 32'hDEADBEEF, lat, rd, b1, pa, pd, pb);
    m_write(0, 32'h005, 4'hF, 32'hDEADBEEF);
    checks++;
    if (lat != 2) begin errors++; $display("FAIL wr_latency: got %0d want 2", lat); end
    checks++;
    if (b1 !== 1'b1) begin errors++; $display("FAIL wr_busy_accept: got %b want 1", b1); end
    checks++;
    if (pa !== 1'b0 || pb !== 1'b0) begin errors++; $display("FAIL wr_post_ack_busy: got %b%b want 00", pa, pb); end
    xact(0, 1'b0, 4'hF, 32'h005, 32'h0, lat, rd, b1, pa, pd, pb);
    checks++;
    if (lat != 2) begin errors++; $display("FAIL rd_latency: got %0d want 2", lat); end
    checks++;
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", rd); end
    checks++;
    if (pd !== 32'h0) begin errors++; $display("FAIL rd_post_dat: got %h want 0", pd); end
  endtask

  task automatic test_byte_lanes();
    int lat; logic [31:0] rd, pd; logic b1, pa, pb;
    xact(0, 1'b1, 4'b0001, 32'h005, 32'h000000AA, lat, rd, b1, pa, pd, pb);
    m_write(0, 32'h005, 4'b0001, 32'h000000AA);
    checks++;
    if (lat != 2) begin errors++; $display("FAIL lane_wr_latency: got %0d want 2", lat); end
    xact(0, 1'b0, 4'hF, 32'h005, 32'h0, lat, rd, b1, pa, pd, pb);
    checks++;
    if (rd !== 32'hDEADBEAA) begin errors++; $display("FAIL lane_rd_data: got %h want deadbeaa", rd); end
    xact(0, 1'b1, 4'b0000, 32'h005, 32'h01020304, lat, rd, b1, pa, pd, pb);
    checks++;
    if (lat != 2) begin errors++; $display("FAIL sel0_wr_ack: got %0d want 2", lat); end
    xact(0, 1'b0, 4'hF, 32'h005, 32'h0, lat, rd, b1, pa, pd, pb);
    checks++;
    if (rd !== 32'hDEADBEAA) begin errors++; $display("FAIL sel0_rd_data: got %h want deadbeaa", rd); end
  endtask

  task automatic test_abort();
    int lat; logic [31:0] rd, pd; logic b1, pa, pb;
    logic ack_seen, busy_wait, busy_after;
    xact(1, 1'b1, 4'hF, 32'h010, 32'h0BADCAFE, lat, rd, b1, pa, pd, pb);
    m_write(1, 32'h010, 4'hF, 32'h0BADCAFE);
    checks++;
    if (lat != 4) begin errors++; $display("FAIL abort_pre_latency: got %0d want 4", lat); end
    ack_seen = 1'b0;
    @(negedge clock);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; sel[1] = 4'hF; adr[1] = 32'h010; dat[1] = 32'h12345678;
    @(posedge clock); #1;
    busy_wait = busy[1];
    ack_seen |= ack[1];
    @(negedge clock);
    stb[1] = 1'b0;
    @(posedge clock); #1;
    busy_after = busy[1];
    ack_seen |= ack[1];
    repeat (6) begin
      @(posedge clock); #1;
      ack_seen |= ack[1];
    end
    @(negedge clock);
    cyc[1] = 1'b0; we[1] = 1'b0;
    checks++;
    if (busy_wait !== 1'b1) begin errors++; $display("FAIL abort_busy_wait: got %b want 1", busy_wait); end
    checks++;
    if (busy_after !== 1'b0) begin errors++; $display("FAIL abort_busy_fall: got %b want 0", busy_after); end
    checks++;
    if (ack_seen !== 1'b0) begin errors++; $display("FAIL abort_no_ack: got %b want 0", ack_seen); end
    xact(1, 1'b0, 4'hF, 32'h010, 32'h0, lat, rd, b1, pa, pd, pb);
    checks++;
    if (rd !== 32'h0BADCAFE) begin errors++; $display("FAIL abort_unchanged: got %h want 0badcafe", rd); end
  endtask

  task automatic test_out_of_range();
    int lat; logic [31:0] rd, pd; logic b1, pa, pb;
    xact(0, 1'b1, 4'hF, 32'h000, 32'h11111111, lat, rd, b1, pa, pd, pb);
    m_write(0, 32'h000, 4'hF, 32'h11111111);
    xact(0, 1'b1, 4'hF, 32'h200, 32'hCAFEF00D, lat, rd, b1, pa, pd, pb);
    checks++;
    if (lat != 2) begin errors++; $display("FAIL oor_wr_ack: got %0d want 2", lat); end
    xact(0, 1'b0, 4'hF, 32'h000, 32'h0, lat, rd, b1, pa, pd, pb);
    checks++;
    if (rd !== 32'h11111111) begin errors++; $display("FAIL oor_word0: got %h want 11111111", rd); end
    xact(0, 1'b0, 4'hF, 32'h200, 32'h0, lat, rd, b1, pa, pd, pb);
    checks++;
    if (lat != 2) begin errors++; $display("FAIL oor_rd_ack: got %0d want 2", lat); end
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL oor_rd_data: got %h want 0", rd); end
  endtask

  task automatic test_back_to_back(input int d);
    int lat, ws, n_ack, exp_cnt, dbl, bad_gap, bad_dat, last;
    logic [31:0] rd, pd, expv; logic b1, pa, pb, prev;
    ws = ws_of(d);
    expv = 32'hA5A50000 + 32'(d);
    xact(d, 1'b1, 4'hF, 32'h033, expv, lat, rd, b1, pa, pd, pb);
    m_write(d, 32'h033, 4'hF, expv);
    exp_cnt = 0;
    for (int t = ws + 1; t <= 20; t += ws + 2) exp_cnt++;
    n_ack = 0; dbl = 0; bad_gap = 0; bad_dat = 0; last = -1; prev = 1'b0;
    @(negedge clock);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = 1'b0; sel[d] = 4'hF; adr[d] = 32'h033;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clock); #1;
      if (ack[d] === 1'b1) begin
        if (prev) dbl++;
        if (last < 0 && n != ws + 1) bad_gap++;
        if (last >= 0 && n - last != ws + 2) bad_gap++;
        if (rdat[d] !== expv) bad_dat++;
        n_ack++;
        last = n;
      end
      prev = ack[d];
    end
    @(negedge clock);
    cyc[d] = 1'b0; stb[d] = 1'b0;
    repeat (ws + 3) @(posedge clock);
    #1;
    checks++;
    if (n_ack != exp_cnt) begin errors++; $display("FAIL b2b_count[%0d]: got %0d want %0d", d, n_ack, exp_cnt); end
    checks++;
    if (dbl != 0) begin errors++; $display("FAIL b2b_double_ack[%0d]: got %0d want 0", d, dbl); end
    checks++;
    if (bad_gap != 0) begin errors++; $display("FAIL b2b_spacing[%0d]: got %0d bad gaps want 0", d, bad_gap); end
    checks++;
    if (bad_dat != 0) begin errors++; $display("FAIL b2b_data[%0d]: got %0d bad words want 0", d, bad_dat); end
    checks++;
    if (busy[d] !== 1'b0) begin errors++; $display("FAIL b2b_idle[%0d]: got busy=%b want 0", d, busy[d]); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd, pd; logic b1, pa, pb;
    xact(1, 1'b1, 4'hF, 32'h020, 32'h55AA55AA, lat, rd, b1, pa, pd, pb);
    m_write(1, 32'h020, 4'hF, 32'h55AA55AA);
    @(negedge clock);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; sel[1] = 4'hF; adr[1] = 32'h020; dat[1] = 32'hFFFFFFFF;
    @(posedge clock); #3;
    reset = 1'b1;
    #1;
    checks++;
    if (ack[1] !== 1'b0) begin errors++; $display("FAIL rstmid_ack: got %b want 0", ack[1]); end
    checks++;
    if (rdat[1] !== 32'h0) begin errors++; $display("FAIL rstmid_dat: got %h want 0", rdat[1]); end
    checks++;
    if (busy[1] !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got busy=%b want 0", busy[1]); end
    @(negedge clock);
    cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (ack[1] !== 1'b0) begin errors++; $display("FAIL rstmid_ack_hold: got %b want 0", ack[1]); end
    @(negedge clock);
    reset = 1'b0;
    xact(1, 1'b0, 4'hF, 32'h020, 32'h0, lat, rd, b1, pa, pd, pb);
    checks++;
    if (rd !== 32'h55AA55AA) begin errors++; $display("FAIL rstmid_prior: got %h want 55aa55aa", rd); end
  endtask

  task automatic test_random(input int d);
    int lat, ws; logic [31:0] rd, pd, a, wd, expv; logic b1, pa, pb, w; logic [3:0] s;
    ws = ws_of(d);
    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      a  = 32'h100 + 32'(i);
      xact(d, 1'b1, 4'hF, a, wd, lat, rd, b1, pa, pd, pb);
      m_write(d, a, 4'hF, wd);
    end
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0)
        a = (32'h1 << $urandom_range(9, 31)) | 32'($urandom_range(0, 511));
      else
        a = 32'h100 + 32'($urandom_range(0, 15));
      w  = 1'($urandom_range(0, 1));
      s  = 4'($urandom_range(0, 15));
      wd = $urandom;
      expv = m_read(d, a);
      xact(d, w, s, a, wd, lat, rd, b1, pa, pd, pb);
      checks++;
      if (lat != ws + 1) begin errors++; $display("FAIL rnd_latency[%0d] op %0d: got %0d want %0d", d, i, lat, ws + 1); end
      if (w) begin
        m_write(d, a, s, wd);
      end else begin
        checks++;
        if (rd !== expv) begin errors++; $display("FAIL rnd_read[%0d] adr %h: got %h want %h", d, a, rd, expv); end
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
      sel[d] = '0; adr[d] = '0; dat[d] = '0;
    end
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_abort();
    test_out_of_range();
    test_back_to_back(0);
    test_back_to_back(1);
    test_reset_mid();
    test_random(0);
    test_random(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
